// File: rtl/booth_mult_ctrl.sv
// -----------------------------------------------------------------------------
// booth_mult_ctrl
//
// Sequencer for an 8-bit signed radix-2 Booth multiply on a shared,
// combinational Alu that lives outside this block.
//
// The controller owns these registers:
//   - the accumulator A
//   - the multiplicand M
//   - the multiplier/shift register Q
//   - the Booth history bit Q_1
//   - the iteration counter
//
// Each RUN cycle it does three things:
//   - issues an Alu opcode chosen from {Q[0],Q_1};
//   - takes the Alu result back;
//   - arithmetic-shifts {Alu_X,Q,Q_1} right by one bit.
//
// Ports:
//   Clk           rising-edge clock
//   Reset         synchronous, active-high reset
//   Start         request pulse, honoured only in IDLE
//   Multiplicand  signed operand M, captured on an accepted Start
//   Multiplier    signed operand Q, captured on an accepted Start
//   Abort         (BOOTH_ABORT_EN only) cancels a RUN without a Done pulse
//   Alu_A         Alu input A (the A register)
//   Alu_M         Alu input M (the M register)
//   Alu_Op        Alu opcode: 0 pass A, 1 A+M, 2 A-M
//   Alu_X         Alu result (combinational in the Alu)
//   Busy          high while in RUN
//   Done          one-cycle pulse when Product becomes valid
//   Product       signed {A,Q}, held until the next accepted Start
//
// Configuration:
//   BOOTH_ABORT_EN  when defined, adds the Abort input.
//
// Parameter limits:
//   - Only N_BITS = 8 is supported; it must match the Alu width.
//   - CNT_W must satisfy 2**CNT_W > N_BITS.
// -----------------------------------------------------------------------------
module booth_mult_ctrl #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [N_BITS-1:0]   Multiplicand,
    input  logic [N_BITS-1:0]   Multiplier,
`ifdef BOOTH_ABORT_EN
    input  logic                Abort,
`endif
    output logic [N_BITS-1:0]   Alu_A,
    output logic [N_BITS-1:0]   Alu_M,
    output logic [2:0]          Alu_Op,
    input  logic [N_BITS-1:0]   Alu_X,
    output logic                Busy,
    output logic                Done,
    output logic [2*N_BITS-1:0] Product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;

    state_t              state;
    logic [N_BITS-1:0]   a_reg;
    logic [N_BITS-1:0]   m_reg;
    logic [N_BITS-1:0]   q_reg;
    logic                q_1;
    logic [CNT_W-1:0]    cnt;
    logic                abort_req;

`ifdef BOOTH_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    assign Alu_A = a_reg;
    assign Alu_M = m_reg;

    // The opcode must follow Q and Q_1 within the same cycle.
    // The Alu result feeds the shift on the very next edge,
    // so a registered opcode would be one iteration late.
    always_comb begin
        // NOTE: the default assignment comes first so that every path
        // drives Alu_Op; a missing default would infer a latch.
        Alu_Op = OP_PASS;
        if (state == RUN) begin
            case ({q_reg[0], q_1})
                2'b01:   Alu_Op = OP_ADD;
                2'b10:   Alu_Op = OP_SUB;
                default: Alu_Op = OP_PASS;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments.
    // Every register therefore sees the pre-edge value of every other
    // register. The shift depends on that: Q_1 takes the old Q[0],
    // and Q takes the old Q[7:1].
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        m_reg <= Multiplicand;
                        q_reg <= Multiplier;
                        cnt   <= CNT_W'(N_BITS);
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (abort_req) begin
                        // Product and M are left untouched.
                        // The previous result stays readable.
                        a_reg <= '0;
                        q_reg <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Arithmetic shift right of {Alu_X, Q, Q_1}.
                        a_reg <= {Alu_X[N_BITS-1], Alu_X[N_BITS-1:1]};
                        q_reg <= {Alu_X[0], q_reg[N_BITS-1:1]};
                        q_1   <= q_reg[0];
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            // {new A, new Q}: the shifted Alu result,
                            // followed by the upper bits of the old Q.
                            Product <= {Alu_X[N_BITS-1], Alu_X, q_reg[N_BITS-1:1]};
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
